chan_scan_seq: RTL and testbench

CHAN_SCAN_SEQ -- requirements
Module: chan_scan_seq

---
 rtl/chan_scan_pkg.sv | 14 +
 rtl/chan_scan_seq.sv | 133 +++++++++++++
 tb/tb_chan_scan_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
package chan_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND,
        DONE
    } state_e;

    localparam logic [3:0] SEL_IDLE = 4'b1111;
    localparam int         MAX_CH   = 8;

endpackage

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: walks an external 8:1 selector and streams samples out.
// Optional per-channel enable mask port is added when CHAN_SCAN_MASK_EN is defined.
module chan_scan_seq
    import chan_scan_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef CHAN_SCAN_MASK_EN
    input  logic [7:0]       chan_mask,
`endif
    output logic [3:0]       sel,
    input  logic [WIDTH-1:0] mux_in,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] LAST_CH = 3'(NCH - 1);

    state_e           state_q, state_d;
    logic [2:0]       ch_q, ch_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       chan_q, chan_d;
    logic             chanEn;

`ifdef CHAN_SCAN_MASK_EN
    logic [7:0]       mask_q, mask_d;

    assign chanEn = mask_q[ch_q];
`else
    assign chanEn = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

`ifdef CHAN_SCAN_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

    // Abort overrides everything, including a handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;
        chan_d  = chan_q;
`ifdef CHAN_SCAN_MASK_EN
        mask_d  = mask_q;
`endif
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ch_d    = '0;
                        state_d = SCAN;
`ifdef CHAN_SCAN_MASK_EN
                        mask_d  = chan_mask;
`endif
                    end
                end
                SCAN: begin
                    if (chanEn) begin
                        data_d  = mux_in;
                        chan_d  = ch_q;
                        state_d = SEND;
                    end else if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (ch_q == LAST_CH) begin
                            state_d = DONE;
                        end else begin
                            ch_d    = ch_q + 3'd1;
                            state_d = SCAN;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The all-ones select parks the external selector on its zero output.
    always_comb begin
        sel = SEL_IDLE;
        if ((state_q == SCAN) || (state_q == SEND)) begin
            sel = {1'b0, ch_q};
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Self-checking bench for chan_scan_seq; honours CHAN_SCAN_MASK_EN when defined.
// A cycle timeline is predicted per pass from the scan rules and compared each cycle.
module tb_chan_scan_seq;

    localparam int WIDTH = 16;
    localparam int NCH   = 8;
    localparam int MAXC  = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             outReady = 1'b0;
    logic [3:0]       sel;
    logic [WIDTH-1:0] muxIn;
    logic [WIDTH-1:0] outData;
    logic [2:0]       outChan;
    logic             outValid;
    logic             busy;
    logic             done;
    logic [15:0]      muxBase = 16'h1000;
`ifdef CHAN_SCAN_MASK_EN
    logic [7:0]       chanMask = 8'hFF;
`endif

    int checkCount = 0;
    int passCount  = 0;

    // Per-cycle ready pattern and predicted outputs, indexed from the start cycle.
    bit          readyArr [MAXC];
    logic [3:0]  expSel   [MAXC];
    bit          expBusy  [MAXC];
    bit          expValid [MAXC];
    bit          expDone  [MAXC];
    logic [15:0] expData  [MAXC];
    logic [2:0]  expChan  [MAXC];
    int          passLen;

    always #5 clk = ~clk;

    // Behaviour of the external selector: zero when parked, otherwise base + channel.
    always_comb muxIn = (sel == 4'hF) ? 16'h0000 : muxBase + {12'd0, sel};

    chan_scan_seq #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
`ifdef CHAN_SCAN_MASK_EN
        .chan_mask(chanMask),
`endif
        .sel      (sel),
        .mux_in   (muxIn),
        .out_data (outData),
        .out_chan (outChan),
        .out_valid(outValid),
        .out_ready(outReady),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic checkCycle(input int k);
        checkOutput($sformatf("sel@%0d", k), 32'(sel), 32'(expSel[k]));
        checkOutput($sformatf("busy@%0d", k), 32'(busy), 32'(expBusy[k]));
        checkOutput($sformatf("valid@%0d", k), 32'(outValid), 32'(expValid[k]));
        checkOutput($sformatf("done@%0d", k), 32'(done), 32'(expDone[k]));
        if (expValid[k]) begin
            checkOutput($sformatf("data@%0d", k), 32'(outData), 32'(expData[k]));
            checkOutput($sformatf("chan@%0d", k), 32'(outChan), 32'(expChan[k]));
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_sel"}, 32'(sel), 32'hF);
        checkOutput({tag, "_data"}, 32'(outData), 32'h0);
        checkOutput({tag, "_chan"}, 32'(outChan), 32'h0);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // Random ready with zero runs capped at three cycles, or ready always high.
    task automatic fillReady(input bit allReady);
        int zeros;
        zeros = 0;
        for (int k = 0; k < MAXC; k++) begin
            if (allReady || zeros >= 3) readyArr[k] = 1'b1;
            else readyArr[k] = ($urandom_range(0, 1) == 1);
            zeros = readyArr[k] ? 0 : zeros + 1;
        end
    endtask

    task automatic setExp(input int k, input logic [3:0] s, input bit b, input bit v,
                          input bit d, input logic [15:0] dat, input logic [2:0] ch);
        expSel[k]   = s;
        expBusy[k]  = b;
        expValid[k] = v;
        expDone[k]  = d;
        expData[k]  = dat;
        expChan[k]  = ch;
    endtask

    // Predict the pass: one scan cycle per channel, enabled channels then sit in
    // send until the first ready cycle, and a single done cycle closes the pass.
    task automatic buildPass(input logic [7:0] mask);
        int t;
        int c;
        setExp(0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        t = 1;
        for (int ch = 0; ch < NCH; ch++) begin
            setExp(t, 4'(ch), 1'b1, 1'b0, 1'b0, 16'h0, 3'd0);
            if (mask[ch]) begin
                c = t + 1;
                forever begin
                    setExp(c, 4'(ch), 1'b1, 1'b1, 1'b0, muxBase + 16'(ch), 3'(ch));
                    if (readyArr[c]) break;
                    c++;
                end
                t = c + 1;
            end else begin
                t = t + 1;
            end
        end
        setExp(t, 4'hF, 1'b1, 1'b0, 1'b1, 16'h0, 3'd0);
        passLen = t + 1;
    endtask

    // Runs one pass starting from an IDLE cycle; ends at the IDLE cycle after done.
    task automatic applyStimulus(input bit hold, input logic [7:0] mask);
        buildPass(mask);
        for (int k = 0; k < passLen; k++) begin
            checkCycle(k);
            outReady = readyArr[k];
            start    = (k == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
`ifdef CHAN_SCAN_MASK_EN
            chanMask = (k == 0) ? mask : 8'($urandom);
`endif
            @(posedge clk); #1;
        end
        start = hold;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            checkOutput("idle_busy", 32'(busy), 32'h0);
            checkOutput("idle_sel", 32'(sel), 32'hF);
            checkOutput("idle_valid", 32'(outValid), 32'h0);
            checkOutput("idle_done", 32'(done), 32'h0);
            start    = 1'b0;
            outReady = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [7:0] randMask();
`ifdef CHAN_SCAN_MASK_EN
        return 8'($urandom);
`else
        return 8'hFF;
`endif
    endfunction

    initial begin
        // Power-on reset and its output values.
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkReset("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        idleCycles(2);

        // Full pass with ready always high and base 16'h1000.
        $display("[TB] basic pass");
        muxBase = 16'h1000;
        fillReady(1'b1);
        applyStimulus(1'b0, 8'hFF);
        idleCycles(2);

        // Consumer stalls five cycles on channel 3.
        $display("[TB] stall on channel 3");
        fillReady(1'b1);
        for (int k = 8; k < 13; k++) readyArr[k] = 1'b0;
        applyStimulus(1'b0, 8'hFF);
        idleCycles(1);

        // Randomized passes.
        $display("[TB] random passes");
        for (int p = 0; p < 4; p++) begin
            muxBase = 16'($urandom);
            fillReady(1'b0);
            applyStimulus(1'b0, randMask());
            idleCycles(1);
        end

`ifdef CHAN_SCAN_MASK_EN
        $display("[TB] mask patterns");
        muxBase = 16'h1000;
        fillReady(1'b0);
        applyStimulus(1'b0, 8'b1010_0101);
        idleCycles(1);
        fillReady(1'b0);
        applyStimulus(1'b0, 8'h00);
        idleCycles(1);
`endif

        // Start held high: passes chain back to back.
        $display("[TB] start held high");
        for (int p = 0; p < 3; p++) begin
            muxBase = 16'($urandom);
            fillReady(1'b0);
            applyStimulus(1'b1, randMask());
        end
        start = 1'b0;
        idleCycles(2);

        // Abort while channel 4 is offered with ready high.
        $display("[TB] abort in send");
        muxBase = 16'h1000;
`ifdef CHAN_SCAN_MASK_EN
        chanMask = 8'hFF;
`endif
        outReady = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_pre_valid", 32'(outValid), 32'h1);
        checkOutput("abort_pre_chan", 32'(outChan), 32'h4);
        checkOutput("abort_pre_data", 32'(outData), 32'h1004);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_sel", 32'(sel), 32'hF);
        checkOutput("abort_valid", 32'(outValid), 32'h0);
        checkOutput("abort_chan_held", 32'(outChan), 32'h4);
        idleCycles(12);

        // Abort out of the first scan cycle.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("abort_scan_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        idleCycles(3);

        // Asynchronous reset mid-pass, then a clean pass from channel 0.
        $display("[TB] reset mid-pass");
        fillReady(1'b1);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checkReset("async");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        muxBase = 16'($urandom);
        fillReady(1'b0);
        applyStimulus(1'b0, 8'hFF);
        idleCycles(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
